// File: rtl/cache_pkg.sv
// Shared widths and payload types for the CacheCore request/response path.
// Request payloads and responses are carried as packed structs.
package cache_pkg;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 512;
  localparam int MASK_W = 64;
  localparam int PORT_W = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [MASK_W-1:0] mask;
    logic              lock;
    logic [PORT_W-1:0] port;
  } cache_req_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              success;
  } cache_resp_t;

endpackage

// File: rtl/cache_tag_fifo.sv
// In-order FIFO of issuing port ids, one entry per request still awaiting a CacheCore response.
// Pushes while full and pops while empty are ignored.
module cache_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap explicitly so non-power-of-2 depths also behave.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cache_req_arbiter.sv
// Round-robin merge of client request streams onto the CacheCore request channel,
// with in-order routing of CacheCore responses back to the issuing client.
module cache_req_arbiter
  import cache_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int MAX_OUTST = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        cli_req_valid,
  output logic [NUM_PORTS-1:0]        cli_req_ready,
  input  logic [NUM_PORTS*ADDR_W-1:0] cli_req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] cli_req_data,
  input  logic [NUM_PORTS*MASK_W-1:0] cli_req_mask,
  input  logic [NUM_PORTS-1:0]        cli_req_lock,
  output logic [NUM_PORTS-1:0]        cli_resp_valid,
  input  logic [NUM_PORTS-1:0]        cli_resp_ready,
  output logic [DATA_W-1:0]           cli_resp_data,
  output logic                        cli_resp_success,
  output logic                        io_request_valid,
  input  logic                        io_request_ready,
  output logic [ADDR_W-1:0]           io_request_bits_addr,
  output logic [DATA_W-1:0]           io_request_bits_data,
  output logic [MASK_W-1:0]           io_request_bits_mask,
  output logic                        io_request_bits_lock,
  output logic [PORT_W-1:0]           io_request_bits_port,
  input  logic                        io_response_valid,
  output logic                        io_response_ready,
  input  logic [DATA_W-1:0]           io_response_bits_data,
  input  logic                        io_response_bits_success,
  output logic                        err_orphan_resp
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     winner;
  logic                 found;
  logic                 slot_free;
  logic                 grant;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 resp_pop;
  logic [PORT_W-1:0]    fifo_head;
  logic [NUM_PORTS-1:0] head_onehot;
  cache_req_t           req_q;
  cache_req_t           req_d;
  cache_resp_t          resp;

  // Rotate-priority search: first valid port at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!found && cli_req_valid[idx]) begin
        found  = 1'b1;
        winner = IDX_W'(idx);
      end
    end
  end

  assign slot_free = ~io_request_valid | io_request_ready;
  assign grant     = reset & slot_free & ~fifo_full & found;

  always_comb begin
    cli_req_ready = '0;
    if (grant) cli_req_ready[winner] = 1'b1;
  end

  always_comb begin
    req_d = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (winner == IDX_W'(i)) begin
        req_d.addr = cli_req_addr[i*ADDR_W +: ADDR_W];
        req_d.data = cli_req_data[i*DATA_W +: DATA_W];
        req_d.mask = cli_req_mask[i*MASK_W +: MASK_W];
        req_d.lock = cli_req_lock[i];
      end
    end
    req_d.port = PORT_W'(winner);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      io_request_valid <= 1'b0;
      req_q            <= '0;
      rr_ptr           <= '0;
      err_orphan_resp  <= 1'b0;
    end else begin
      if (grant) begin
        req_q            <= req_d;
        io_request_valid <= 1'b1;
        rr_ptr           <= (winner == IDX_W'(NUM_PORTS-1)) ? '0 : winner + 1'b1;
      end else if (io_request_ready) begin
        io_request_valid <= 1'b0;
      end
      if (io_response_valid && fifo_empty) err_orphan_resp <= 1'b1;
    end
  end

  assign io_request_bits_addr = req_q.addr;
  assign io_request_bits_data = req_q.data;
  assign io_request_bits_mask = req_q.mask;
  assign io_request_bits_lock = req_q.lock;
  assign io_request_bits_port = req_q.port;

  cache_tag_fifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH (PORT_W)
  ) u_tag_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (grant),
    .push_data (PORT_W'(winner)),
    .pop       (resp_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  // The oldest outstanding tag owns whatever response CacheCore presents.
  always_comb begin
    head_onehot = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      head_onehot[i] = (fifo_head == PORT_W'(i));
    end
  end

  assign cli_resp_valid    = {NUM_PORTS{io_response_valid & ~fifo_empty}} & head_onehot;
  assign io_response_ready = ~fifo_empty & (|(cli_resp_ready & head_onehot));
  assign resp_pop          = io_response_valid & io_response_ready;

  assign resp             = '{data: io_response_bits_data, success: io_response_bits_success};
  assign cli_resp_data    = resp.data;
  assign cli_resp_success = resp.success;

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Randomized and directed stimulus for cache_req_arbiter, checked every cycle against a
// queue-based model of round-robin grant, the output register and in-order response routing.
module tb_cache_req_arbiter;
  import cache_pkg::*;

  localparam int N    = 4;
  localparam int MAXO = 4;

  logic                clock = 1'b0;
  logic                reset;
  logic [N-1:0]        cli_req_valid;
  logic [N-1:0]        cli_req_ready;
  logic [N*ADDR_W-1:0] cli_req_addr;
  logic [N*DATA_W-1:0] cli_req_data;
  logic [N*MASK_W-1:0] cli_req_mask;
  logic [N-1:0]        cli_req_lock;
  logic [N-1:0]        cli_resp_valid;
  logic [N-1:0]        cli_resp_ready;
  logic [DATA_W-1:0]   cli_resp_data;
  logic                cli_resp_success;
  logic                io_request_valid;
  logic                io_request_ready;
  logic [ADDR_W-1:0]   io_request_bits_addr;
  logic [DATA_W-1:0]   io_request_bits_data;
  logic [MASK_W-1:0]   io_request_bits_mask;
  logic                io_request_bits_lock;
  logic [PORT_W-1:0]   io_request_bits_port;
  logic                io_response_valid;
  logic                io_response_ready;
  logic [DATA_W-1:0]   io_response_bits_data;
  logic                io_response_bits_success;
  logic                err_orphan_resp;

  cache_req_arbiter #(.NUM_PORTS(N), .MAX_OUTST(MAXO)) dut (
    .clock                    (clock),
    .reset                    (reset),
    .cli_req_valid            (cli_req_valid),
    .cli_req_ready            (cli_req_ready),
    .cli_req_addr             (cli_req_addr),
    .cli_req_data             (cli_req_data),
    .cli_req_mask             (cli_req_mask),
    .cli_req_lock             (cli_req_lock),
    .cli_resp_valid           (cli_resp_valid),
    .cli_resp_ready           (cli_resp_ready),
    .cli_resp_data            (cli_resp_data),
    .cli_resp_success         (cli_resp_success),
    .io_request_valid         (io_request_valid),
    .io_request_ready         (io_request_ready),
    .io_request_bits_addr     (io_request_bits_addr),
    .io_request_bits_data     (io_request_bits_data),
    .io_request_bits_mask     (io_request_bits_mask),
    .io_request_bits_lock     (io_request_bits_lock),
    .io_request_bits_port     (io_request_bits_port),
    .io_response_valid        (io_response_valid),
    .io_response_ready        (io_response_ready),
    .io_response_bits_data    (io_response_bits_data),
    .io_response_bits_success (io_response_bits_success),
    .err_orphan_resp          (err_orphan_resp)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  logic [ADDR_W-1:0] p_addr [N];
  logic [DATA_W-1:0] p_data [N];
  logic [MASK_W-1:0] p_mask [N];
  logic              p_lock [N];
  bit                rand_payload;

  // Reference model: rotating pointer, queue of outstanding port ids, one held request.
  int                m_rr;
  int                m_q[$];
  bit                m_valid;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  logic [MASK_W-1:0] m_mask;
  logic              m_lock;
  int                m_port;
  bit                m_err;

  logic [N-1:0] last_grant;
  logic [N-1:0] last_resp_valid;

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] observed,
                             input logic [DATA_W-1:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [DATA_W-1:0] random512();
    logic [DATA_W-1:0] v;
    for (int k = 0; k < DATA_W/32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic randomizePayload();
    for (int p = 0; p < N; p++) begin
      p_addr[p] = ADDR_W'($urandom);
      p_data[p] = random512();
      p_mask[p] = {$urandom, $urandom};
      p_lock[p] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic packPayload();
    for (int p = 0; p < N; p++) begin
      cli_req_addr[p*ADDR_W +: ADDR_W] = p_addr[p];
      cli_req_data[p*DATA_W +: DATA_W] = p_data[p];
      cli_req_mask[p*MASK_W +: MASK_W] = p_mask[p];
      cli_req_lock[p]                  = p_lock[p];
    end
  endtask

  task automatic modelReset();
    m_rr    = 0;
    m_q.delete();
    m_valid = 0;
    m_addr  = '0;
    m_data  = '0;
    m_mask  = '0;
    m_lock  = 1'b0;
    m_port  = 0;
    m_err   = 0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_req_valid"}, io_request_valid, 0);
    checkOutput({tag, "_addr"}, io_request_bits_addr, 0);
    checkOutput({tag, "_data"}, io_request_bits_data, 0);
    checkOutput({tag, "_mask"}, io_request_bits_mask, 0);
    checkOutput({tag, "_lock"}, io_request_bits_lock, 0);
    checkOutput({tag, "_port"}, io_request_bits_port, 0);
    checkOutput({tag, "_cli_req_ready"}, cli_req_ready, 0);
    checkOutput({tag, "_cli_resp_valid"}, cli_resp_valid, 0);
    checkOutput({tag, "_io_resp_ready"}, io_response_ready, 0);
    checkOutput({tag, "_err_orphan"}, err_orphan_resp, 0);
  endtask

  task automatic doReset();
    @(negedge clock);
    reset             = 1'b0;
    cli_req_valid     = '0;
    io_response_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    modelReset();
  endtask

  // One cycle: drive inputs at negedge, compare against the model, then advance the model.
  task automatic applyStimulus(input logic [N-1:0] vld, input logic req_rdy, input logic rsp_vld,
                               input logic [N-1:0] rsp_rdy, input logic [DATA_W-1:0] rsp_data,
                               input logic rsp_success);
    int win;
    int h;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] exp_rv;
    logic exp_iorr;
    @(negedge clock);
    if (rand_payload) randomizePayload();
    packPayload();
    cli_req_valid            = vld;
    io_request_ready         = req_rdy;
    io_response_valid        = rsp_vld;
    cli_resp_ready           = rsp_rdy;
    io_response_bits_data    = rsp_data;
    io_response_bits_success = rsp_success;
    #1;
    checkOutput("req_valid", io_request_valid, m_valid);
    if (m_valid) begin
      checkOutput("req_addr", io_request_bits_addr, m_addr);
      checkOutput("req_data", io_request_bits_data, m_data);
      checkOutput("req_mask", io_request_bits_mask, m_mask);
      checkOutput("req_lock", io_request_bits_lock, m_lock);
      checkOutput("req_port", io_request_bits_port, m_port);
    end
    checkOutput("err_orphan", err_orphan_resp, m_err);

    win = -1;
    if ((!m_valid || req_rdy) && m_q.size() < MAXO) begin
      for (int k = 0; k < N; k++) begin
        if (win < 0 && vld[(m_rr + k) % N]) win = (m_rr + k) % N;
      end
    end
    exp_rdy = '0;
    if (win >= 0) exp_rdy[win] = 1'b1;
    exp_rv   = '0;
    exp_iorr = 1'b0;
    if (m_q.size() > 0) begin
      h = m_q[0];
      if (rsp_vld) exp_rv[h] = 1'b1;
      exp_iorr = rsp_rdy[h];
    end
    checkOutput("cli_req_ready", cli_req_ready, exp_rdy);
    checkOutput("cli_resp_valid", cli_resp_valid, exp_rv);
    checkOutput("io_resp_ready", io_response_ready, exp_iorr);
    checkOutput("cli_resp_data", cli_resp_data, rsp_data);
    checkOutput("cli_resp_success", cli_resp_success, rsp_success);
    last_grant      = cli_req_ready;
    last_resp_valid = cli_resp_valid;

    if (rsp_vld && m_q.size() == 0) m_err = 1;
    if (rsp_vld && exp_iorr) void'(m_q.pop_front());
    if (win >= 0) begin
      m_q.push_back(win);
      m_valid = 1;
      m_addr  = p_addr[win];
      m_data  = p_data[win];
      m_mask  = p_mask[win];
      m_lock  = p_lock[win];
      m_port  = win;
      m_rr    = (win + 1) % N;
    end else if (req_rdy) begin
      m_valid = 0;
    end
  endtask

  function automatic int onehotIndex(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  initial begin
    int grants;
    reset                    = 1'b0;
    cli_req_valid            = '0;
    cli_resp_ready           = '0;
    io_request_ready         = 1'b0;
    io_response_valid        = 1'b0;
    io_response_bits_data    = '0;
    io_response_bits_success = 1'b0;
    rand_payload             = 1'b1;
    randomizePayload();
    packPayload();
    modelReset();

    // Reset state with every request and a response pending.
    repeat (2) @(negedge clock);
    cli_req_valid     = '1;
    io_response_valid = 1'b1;
    cli_resp_ready    = '1;
    #1;
    checkResetState("rst");
    cli_req_valid     = '0;
    io_response_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;

    // Single request from port 2 with a fixed payload, then its response.
    rand_payload = 1'b0;
    p_addr[2] = 24'h40;
    p_data[2] = 512'h2;
    p_mask[2] = '1;
    p_lock[2] = 1'b1;
    applyStimulus(4'b0100, 1'b1, 1'b0, '0, '0, 1'b0);
    checkOutput("t1_grant", last_grant, 4'b0100);
    applyStimulus(4'b0000, 1'b0, 1'b0, '0, '0, 1'b0);
    checkOutput("t1_port", io_request_bits_port, 4'h2);
    checkOutput("t1_lock", io_request_bits_lock, 1'b1);
    checkOutput("t1_addr", io_request_bits_addr, 24'h40);
    applyStimulus(4'b0000, 1'b1, 1'b1, 4'b0100, 512'h3, 1'b1);
    checkOutput("t1_resp_valid", last_resp_valid, 4'b0100);
    rand_payload = 1'b1;

    // All ports valid, immediate responses: strict rotation from port 0.
    doReset();
    for (int i = 0; i < 12; i++) begin
      applyStimulus(4'hF, 1'b1, m_q.size() > 0, 4'hF, random512(), 1'($urandom_range(0, 1)));
      checkOutput("t2_order", onehotIndex(last_grant), i % N);
    end

    // Downstream stalled: one grant, payload held, then release.
    doReset();
    grants = 0;
    for (int i = 0; i < 11; i++) begin
      applyStimulus(4'b0011, 1'b0, 1'b0, '0, random512(), 1'b0);
      if (last_grant != 0) grants++;
    end
    checkOutput("t3_grants", grants, 1);
    checkOutput("t3_port", io_request_bits_port, 0);
    applyStimulus(4'b0011, 1'b1, 1'b0, '0, random512(), 1'b0);
    checkOutput("t3_release", last_grant, 4'b0010);

    // No responses: tag FIFO fills at MAX_OUTST, one response frees one slot.
    doReset();
    grants = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(4'hF, 1'b1, 1'b0, '0, random512(), 1'b0);
      if (last_grant != 0) grants++;
    end
    checkOutput("t4_grants", grants, MAXO);
    applyStimulus(4'hF, 1'b1, 1'b1, 4'hF, random512(), 1'b1);
    checkOutput("t4_full_pop", last_grant, 4'b0000);
    applyStimulus(4'hF, 1'b1, 1'b0, '0, random512(), 1'b0);
    checkOutput("t4_refill", last_grant, 4'b0001);
    applyStimulus(4'hF, 1'b1, 1'b0, '0, random512(), 1'b0);
    checkOutput("t4_full_again", last_grant, 4'b0000);

    // Orphan response sets a sticky error.
    doReset();
    applyStimulus(4'b0000, 1'b1, 1'b1, 4'hF, random512(), 1'b1);
    repeat (3) applyStimulus(4'b0000, 1'b1, 1'b0, '0, random512(), 1'b0);
    checkOutput("t5_err_sticky", err_orphan_resp, 1'b1);

    // Reset mid-burst with two outstanding and a held output.
    doReset();
    applyStimulus(4'hF, 1'b1, 1'b0, '0, random512(), 1'b0);
    applyStimulus(4'hF, 1'b1, 1'b0, '0, random512(), 1'b0);
    applyStimulus(4'hF, 1'b0, 1'b0, '0, random512(), 1'b0);
    #2;
    reset             = 1'b0;
    io_response_valid = 1'b1;
    cli_resp_ready    = '1;
    #1;
    checkResetState("t6");
    @(negedge clock);
    cli_req_valid     = '0;
    io_response_valid = 1'b0;
    reset             = 1'b1;
    modelReset();
    applyStimulus(4'hF, 1'b1, 1'b0, '0, random512(), 1'b0);
    checkOutput("t6_first_grant", last_grant, 4'b0001);

    // Randomized traffic with occasional orphan responses.
    doReset();
    for (int i = 0; i < 400; i++) begin
      logic rv;
      rv = ($urandom_range(0, 2) != 0) && (m_q.size() > 0 || $urandom_range(0, 40) == 0);
      applyStimulus(N'($urandom), $urandom_range(0, 3) != 0, rv, N'($urandom), random512(),
                    1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
